// File: rtl/rf_wb_arb_if.sv
// Writeback arbiter bus: two writeback requesters, issue/decode pending lookups and the
// register-file write port, bundled for connection to rf_wb_arb.
interface rf_wb_arb_if;
  logic        v0;
  logic [4:0]  rd0;
  logic [31:0] wd0;
  logic        rdy0;
  logic        v1;
  logic [4:0]  rd1;
  logic [31:0] wd1;
  logic        rdy1;
  logic        iss_v;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        pend1;
  logic        pend2;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;

  modport master (
    output v0, rd0, wd0, v1, rd1, wd1, iss_v, iss_rd, rs1, rs2,
    input  rdy0, rdy1, pend1, pend2, WE3, A3, WD3
  );

  modport slave (
    input  v0, rd0, wd0, v1, rd1, wd1, iss_v, iss_rd, rs1, rs2,
    output rdy0, rdy1, pend1, pend2, WE3, A3, WD3
  );
endinterface

// File: rtl/rf_wb_arb.sv
// Two-port register-file writeback arbiter with long-latency pending scoreboard.
// Define RF_WB_RR_EN for round-robin arbitration instead of fixed priority + starvation guard.
module rf_wb_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  rf_wb_arb_if.slave   bus
);

  logic        rdy0_s;
  logic        rdy1_s;
  logic        we_q,   we_d;
  logic [4:0]  a_q,    a_d;
  logic [31:0] wd_q,   wd_d;
  logic [31:0] mask_q, mask_d;

`ifdef RF_WB_RR_EN
  logic ptr_q, ptr_d;

  // Round-robin grant: the pointed-to port wins a conflict and then yields the pointer.
  always_comb begin
    rdy0_s = 1'b0;
    rdy1_s = 1'b0;
    ptr_d  = ptr_q;
    if (reset_n) begin
      rdy0_s = bus.v0 && (!bus.v1 || !ptr_q);
      rdy1_s = bus.v1 && (!bus.v0 ||  ptr_q);
    end else begin
      rdy0_s = 1'b0;
      rdy1_s = 1'b0;
    end
    if (!ptr_q && rdy0_s) begin
      ptr_d = 1'b1;
    end else if (ptr_q && rdy1_s) begin
      ptr_d = 1'b0;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          force1_s;

  // Fixed priority to port 0, overridden once port 1 has been refused LIMIT cycles in a row.
  always_comb begin
    rdy0_s   = 1'b0;
    rdy1_s   = 1'b0;
    cnt_d    = cnt_q;
    force1_s = bus.v1 && (cnt_q == LIMIT);
    if (reset_n) begin
      rdy0_s = bus.v0 && !force1_s;
      rdy1_s = bus.v1 && (!bus.v0 || force1_s);
    end else begin
      rdy0_s = 1'b0;
      rdy1_s = 1'b0;
    end
    if (!bus.v1 || rdy1_s) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Select the accepted request for the write port; rd==0 completes the handshake but never writes.
  always_comb begin
    we_d = 1'b0;
    a_d  = a_q;
    wd_d = wd_q;
    if (rdy0_s) begin
      we_d = (bus.rd0 != 5'd0);
      a_d  = bus.rd0;
      wd_d = bus.wd0;
    end else if (rdy1_s) begin
      we_d = (bus.rd1 != 5'd0);
      a_d  = bus.rd1;
      wd_d = bus.wd1;
    end else begin
      we_d = 1'b0;
    end
  end

  // Pending mask: clear on port-1 acceptance, then set on issue so a re-issue stays pending.
  always_comb begin
    mask_d = mask_q;
    if (rdy1_s) begin
      mask_d[bus.rd1] = 1'b0;
    end else begin
      mask_d = mask_q;
    end
    if (bus.iss_v && (bus.iss_rd != 5'd0)) begin
      mask_d[bus.iss_rd] = 1'b1;
    end else begin
      mask_d = mask_d;
    end
    mask_d[0] = 1'b0;
  end

  // Registered write port and pending mask; reset drops any write not yet retired.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q   <= 1'b0;
      a_q    <= 5'd0;
      wd_q   <= 32'd0;
      mask_q <= 32'd0;
    end else begin
      we_q   <= we_d;
      a_q    <= a_d;
      wd_q   <= wd_d;
      mask_q <= mask_d;
    end
  end

  assign bus.rdy0  = rdy0_s;
  assign bus.rdy1  = rdy1_s;
  assign bus.WE3   = we_q;
  assign bus.A3    = a_q;
  assign bus.WD3   = wd_q;
  assign bus.pend1 = mask_q[bus.rs1];
  assign bus.pend2 = mask_q[bus.rs2];

endmodule

// File: tb/tb_rf_wb_arb.sv
// Directed self-checking bench for rf_wb_arb (fixed-priority or RF_WB_RR_EN build).
module tb_rf_wb_arb;
  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  rf_wb_arb_if bus ();

  rf_wb_arb #(.STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.v0 = 1'b0; bus.rd0 = 5'd0; bus.wd0 = 32'd0;
    bus.v1 = 1'b0; bus.rd1 = 5'd0; bus.wd1 = 32'd0;
    bus.iss_v = 1'b0; bus.iss_rd = 5'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    bus.rs1 = 5'd3; bus.rs2 = 5'd4;
    bus.v0 = 1'b1; bus.rd0 = 5'd3; bus.v1 = 1'b1; bus.rd1 = 5'd4;
    @(negedge clk); #1;
    checks += 5;
    if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL reset_we3 got=%b exp=0", bus.WE3); end
    if (bus.A3 !== 5'd0) begin errors++; $display("FAIL reset_a3 got=%0d exp=0", bus.A3); end
    if (bus.WD3 !== 32'd0) begin errors++; $display("FAIL reset_wd3 got=%h exp=0", bus.WD3); end
    if (bus.rdy0 !== 1'b0 || bus.rdy1 !== 1'b0) begin
      errors++; $display("FAIL reset_rdy got=%b%b exp=00", bus.rdy0, bus.rdy1);
    end
    if (bus.pend1 !== 1'b0 || bus.pend2 !== 1'b0) begin
      errors++; $display("FAIL reset_pend got=%b%b exp=00", bus.pend1, bus.pend2);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL reset_held_we3 got=%b exp=0", bus.WE3); end
    @(negedge clk);
    idle();
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.v0 = 1'b1; bus.rd0 = 5'd5; bus.wd0 = 32'hDEADBEEF;
    #1;
    checks += 2;
    if (bus.rdy0 !== 1'b1) begin errors++; $display("FAIL single_rdy0 got=%b exp=1", bus.rdy0); end
    if (bus.rdy1 !== 1'b0) begin errors++; $display("FAIL single_rdy1 got=%b exp=0", bus.rdy1); end
    @(posedge clk); #1;
    idle();
    checks += 3;
    if (bus.WE3 !== 1'b1) begin errors++; $display("FAIL single_we3 got=%b exp=1", bus.WE3); end
    if (bus.A3 !== 5'd5) begin errors++; $display("FAIL single_a3 got=%0d exp=5", bus.A3); end
    if (bus.WD3 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wd3 got=%h exp=deadbeef", bus.WD3); end
    @(posedge clk); #1;
    checks++;
    if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL single_we3_fall got=%b exp=0", bus.WE3); end
  endtask

  task automatic test_starve();
    logic [8:0] v1_pat;
    logic [8:0] g1_pat;
    logic       exp1;
    logic [4:0] exp_a;
    // Ten back-to-back conflicts: port 1 wins only in cycles 4 and 9.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.v0 = 1'b1; bus.rd0 = 5'(i + 1);  bus.wd0 = 32'(i);
      bus.v1 = 1'b1; bus.rd1 = 5'(i + 20); bus.wd1 = 32'(i + 100);
      #1;
      exp1 = (i == 4) || (i == 9);
      exp_a = exp1 ? 5'(i + 20) : 5'(i + 1);
      checks += 2;
      if (bus.rdy0 !== !exp1) begin errors++; $display("FAIL starve_rdy0[%0d] got=%b exp=%b", i, bus.rdy0, !exp1); end
      if (bus.rdy1 !== exp1) begin errors++; $display("FAIL starve_rdy1[%0d] got=%b exp=%b", i, bus.rdy1, exp1); end
      @(posedge clk); #1;
      checks++;
      if (bus.A3 !== exp_a) begin errors++; $display("FAIL starve_a3[%0d] got=%0d exp=%0d", i, bus.A3, exp_a); end
    end
    // A cycle with v1 low restarts the refusal count.
    v1_pat = 9'b111110111;
    g1_pat = 9'b100000000;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.v0 = 1'b1; bus.rd0 = 5'd2; bus.v1 = v1_pat[i]; bus.rd1 = 5'd21;
      #1;
      checks++;
      if (bus.rdy1 !== g1_pat[i] || bus.rdy0 !== !g1_pat[i]) begin
        errors++;
        $display("FAIL starve_clear[%0d] got=%b%b exp=%b%b", i, bus.rdy0, bus.rdy1, !g1_pat[i], g1_pat[i]);
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_rr();
    @(negedge clk);
    reset_n = 1'b0;
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.v0 = 1'b1; bus.rd0 = 5'd3; bus.v1 = 1'b1; bus.rd1 = 5'd4;
      #1;
      checks++;
      if (bus.rdy0 !== (i % 2 == 0) || bus.rdy1 !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL rr_grant[%0d] got=%b%b exp=%b%b", i, bus.rdy0, bus.rdy1, (i % 2 == 0), (i % 2 == 1));
      end
      @(posedge clk); #1;
      checks++;
      if (bus.WE3 !== 1'b1) begin errors++; $display("FAIL rr_we3[%0d] got=%b exp=1", i, bus.WE3); end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_pending();
    @(negedge clk);
    bus.iss_v = 1'b1; bus.iss_rd = 5'd7; bus.rs1 = 5'd7; bus.rs2 = 5'd3;
    #1;
    checks++;
    if (bus.pend1 !== 1'b0) begin errors++; $display("FAIL pend_no_bypass got=%b exp=0", bus.pend1); end
    @(posedge clk); #1;
    idle();
    checks += 2;
    if (bus.pend1 !== 1'b1) begin errors++; $display("FAIL pend_set got=%b exp=1", bus.pend1); end
    if (bus.pend2 !== 1'b0) begin errors++; $display("FAIL pend_other got=%b exp=0", bus.pend2); end
    @(negedge clk);
    bus.v1 = 1'b1; bus.rd1 = 5'd7; bus.wd1 = 32'h0000_0077;
    bus.iss_v = 1'b1; bus.iss_rd = 5'd7;
    #1;
    checks++;
    if (bus.rdy1 !== 1'b1) begin errors++; $display("FAIL pend_rdy1 got=%b exp=1", bus.rdy1); end
    @(posedge clk); #1;
    idle();
    checks += 3;
    if (bus.pend1 !== 1'b1) begin errors++; $display("FAIL pend_set_wins got=%b exp=1", bus.pend1); end
    if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd7) begin
      errors++; $display("FAIL pend_write got=%b/%0d exp=1/7", bus.WE3, bus.A3);
    end
    if (bus.WD3 !== 32'h0000_0077) begin errors++; $display("FAIL pend_wd3 got=%h exp=00000077", bus.WD3); end
    @(negedge clk);
    bus.v1 = 1'b1; bus.rd1 = 5'd7;
    @(posedge clk); #1;
    idle();
    checks++;
    if (bus.pend1 !== 1'b0) begin errors++; $display("FAIL pend_clear got=%b exp=0", bus.pend1); end
  endtask

  task automatic test_rd0();
    @(negedge clk);
    bus.v1 = 1'b1; bus.rd1 = 5'd0; bus.wd1 = 32'h0000_1234;
    bus.iss_v = 1'b1; bus.iss_rd = 5'd0; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    #1;
    checks++;
    if (bus.rdy1 !== 1'b1) begin errors++; $display("FAIL rd0_rdy1 got=%b exp=1", bus.rdy1); end
    @(posedge clk); #1;
    idle();
    checks += 2;
    if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL rd0_we3 got=%b exp=0", bus.WE3); end
    if (bus.pend1 !== 1'b0 || bus.pend2 !== 1'b0) begin
      errors++; $display("FAIL rd0_pend got=%b%b exp=00", bus.pend1, bus.pend2);
    end
    @(negedge clk);
    bus.v0 = 1'b1; bus.rd0 = 5'd0; bus.wd0 = 32'h0000_5678;
    @(posedge clk); #1;
    idle();
    checks++;
    if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL rd0_port0_we3 got=%b exp=0", bus.WE3); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.v0 = 1'b1; bus.rd0 = 5'd9; bus.wd0 = 32'hCAFEF00D;
    bus.iss_v = 1'b1; bus.iss_rd = 5'd12; bus.rs1 = 5'd12; bus.rs2 = 5'd9;
    @(posedge clk); #1;
    idle();
    checks += 2;
    if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd9) begin
      errors++; $display("FAIL mid_pre_we3 got=%b/%0d exp=1/9", bus.WE3, bus.A3);
    end
    if (bus.pend1 !== 1'b1) begin errors++; $display("FAIL mid_pre_pend got=%b exp=1", bus.pend1); end
    #1;
    reset_n = 1'b0;
    #1;
    checks += 3;
    if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL mid_we3_async got=%b exp=0", bus.WE3); end
    if (bus.A3 !== 5'd0 || bus.WD3 !== 32'd0) begin
      errors++; $display("FAIL mid_port_clear got=%0d/%h exp=0/0", bus.A3, bus.WD3);
    end
    if (bus.pend1 !== 1'b0 || bus.pend2 !== 1'b0) begin
      errors++; $display("FAIL mid_mask got=%b%b exp=00", bus.pend1, bus.pend2);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus.v0 = 1'b1; bus.rd0 = 5'd3; bus.wd0 = 32'h0000_0333;
    #1;
    checks++;
    if (bus.rdy0 !== 1'b1) begin errors++; $display("FAIL post_reset_rdy0 got=%b exp=1", bus.rdy0); end
    @(posedge clk); #1;
    idle();
    checks += 2;
    if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd3) begin
      errors++; $display("FAIL post_reset_write got=%b/%0d exp=1/3", bus.WE3, bus.A3);
    end
    if (bus.pend1 !== 1'b0) begin errors++; $display("FAIL post_reset_mask got=%b exp=0", bus.pend1); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
`ifdef RF_WB_RR_EN
    test_rr();
`else
    test_starve();
`endif
    test_pending();
    test_rd0();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
